ext_debounce: RTL

Front-end conditioning stage for slow or noisy external pins such as header inputs, buttons and signal-generator lines. It sits directly upstream of the edge-counting LED block and replaces that block's private two-flop latch. It synchronises the raw pin into CLK_IN and accepts a level change only after it has been stable for STABLE_CYCLES clocks. It emits a clean level plus single-cycle rise and fall pulses that the counter consumes directly.

---
 rtl/ext_io_pkg.sv | 17 +
 rtl/ext_debounce_if.sv | 28 ++
 rtl/ext_debounce_sync2ff.sv | 24 ++
 rtl/ext_debounce.sv | 81 ++++++++
 4 files changed

// File: rtl/ext_io_pkg.sv
// Shared constants and helpers for external-pin conditioning blocks.
package ext_io_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 16;
  localparam logic        INIT_LEVEL_DEF    = 1'b0;

  // Number of bits needed to hold the value v (at least 1).
  function automatic int unsigned bits_for(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ext_debounce_if.sv
// Pin-side and consumer-side signals of the debounce stage; master = debouncer, slave = pin driver / edge counter.
interface ext_debounce_if #(
  parameter int unsigned GLITCH_W = 8
) ();

  logic                PIN_i;
  logic                LEVEL_o;
  logic                RISE_o;
  logic                FALL_o;
  logic [GLITCH_W-1:0] GLITCH_CNT_o;

  modport master (
    input  PIN_i,
    output LEVEL_o,
    output RISE_o,
    output FALL_o,
    output GLITCH_CNT_o
  );

  modport slave (
    output PIN_i,
    input  LEVEL_o,
    input  RISE_o,
    input  FALL_o,
    input  GLITCH_CNT_o
  );

endinterface

// File: rtl/ext_debounce_sync2ff.sv
// Generic two-flop synchroniser with a parameterised reset value; 2-cycle latency, no backpressure.
module sync2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic d,
  output logic q
);

  // First stage may go metastable; only the second stage is consumed.
  logic meta;

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ext_debounce.sv
// Debounces an async pin into CLK_IN: level + rise/fall pulses STABLE_CYCLES+2 edges after capture; no backpressure.
// EXT_DEBOUNCE_GLITCH_CNT_EN enables the saturating rejected-glitch counter (otherwise GLITCH_CNT_o is 0).
module ext_debounce
  import ext_io_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GLITCH_W      = 8,
  parameter logic        INIT_LEVEL    = INIT_LEVEL_DEF
) (
  input  logic          CLK_IN,
  input  logic          RST_IN,
  ext_debounce_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (CNT_W < bits_for(STABLE_CYCLES - 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for STABLE_CYCLES");
  end

  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  sync2ff #(.RST_VAL(INIT_LEVEL)) u_sync (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .d      (bus.PIN_i),
    .q      (sync_q)
  );

  // cnt counts consecutive edges on which the synchronised pin disagrees with the level.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      level_q <= INIT_LEVEL;
      cnt     <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q != level_q) begin
        if (cnt == CNT_LAST) begin
          level_q <= sync_q;
          cnt     <= '0;
          rise_q  <= sync_q;
          fall_q  <= ~sync_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef EXT_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q;

  // A run that falls back to the current level before acceptance is a rejected glitch.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      glitch_q <= '0;
    end else if ((sync_q == level_q) && (cnt != '0) && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign bus.GLITCH_CNT_o = glitch_q;
`else
  assign bus.GLITCH_CNT_o = {GLITCH_W{1'b0}};
`endif

  assign bus.LEVEL_o = level_q;
  assign bus.RISE_o  = rise_q;
  assign bus.FALL_o  = fall_q;

endmodule
